// File: rtl/mem_access_unit_if.sv
// Request/response and data-RAM bus between the MEM stage and mem_access_unit.
// The unit side is "slave"; the pipeline plus RAM side is "master".
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_wdata, mem_read, mem_write
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-addressed data RAM without byte enables.
// Sub-word stores are read-modify-write; loads return sign/zero-extended lanes.
module mem_access_unit #(
  parameter int unsigned ADDR_LIMIT = 1024
) (
  input logic               clk,
  input logic               rst,
  mem_access_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q, word_q, rdata_q;
  logic [1:0]  size_q;
  logic        signed_q, write_q, err_q;
  logic        accept, req_err;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val, merged;

  assign bus.req_ready = (state == IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;

  assign req_err = (bus.req_size == 2'b11)
                || (bus.req_size == 2'b01 && bus.req_addr[0])
                || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
                || (bus.req_addr >= ADDR_LIMIT);

  // Extracting straight from mem_rdata at the RD edge equals extracting from
  // the captured word, and lets resp_rdata be registered in the same cycle.
  assign lane_b = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign lane_h = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    load_val = bus.mem_rdata;
    case (size_q)
      2'b00:   load_val = {{24{signed_q & lane_b[7]}}, lane_b};
      2'b01:   load_val = {{16{signed_q & lane_h[15]}}, lane_h};
      default: load_val = bus.mem_rdata;
    endcase
  end

  always_comb begin
    merged = word_q;
    case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) begin
        if (req_err)                    state_nxt = RESP;
        else if (!bus.req_write)        state_nxt = RD;
        else if (bus.req_size == 2'b10) state_nxt = WR;
        else                            state_nxt = RD;
      end
      RD:      state_nxt = write_q ? WR : RESP;
      WR:      state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes decode from state alone, so an async reset drops mem_write at once.
  always_comb begin
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state)
      RD: begin
        bus.mem_read = 1'b1;
        bus.mem_addr = {addr_q[31:2], 2'b00};
      end
      WR: begin
        bus.mem_write = 1'b1;
        bus.mem_addr  = {addr_q[31:2], 2'b00};
        bus.mem_wdata = merged;
      end
      default: ;
    endcase
  end

  assign bus.resp_valid = (state == RESP);
  assign bus.resp_err   = (state == RESP) && err_q;
  assign bus.resp_rdata = rdata_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      word_q   <= '0;
      rdata_q  <= '0;
    end else begin
      if (accept) begin
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        size_q   <= bus.req_size;
        signed_q <= bus.req_signed;
        write_q  <= bus.req_write;
        err_q    <= req_err;
        if (req_err) rdata_q <= '0;
      end
      if (state == RD) begin
        word_q <= bus.mem_rdata;
        if (!write_q) rdata_q <= load_val;
      end
      if (state == WR) rdata_q <= '0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random
// traffic compared against a byte-array reference model.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if bus ();

  mem_access_unit #(.ADDR_LIMIT(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Data RAM: combinational read, write commits on the falling edge.
  logic [31:0] ram [256];
  assign bus.mem_rdata = ram[bus.mem_addr[9:2]];
  always @(negedge clk) if (bus.mem_write) ram[bus.mem_addr[9:2]] <= bus.mem_wdata;

  logic [7:0] ref_bytes [1024];
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed memory, little-endian assembly, arithmetic extension.
  task automatic model(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [31:0] wd,
                       output logic err, output logic [31:0] rd, output logic [31:0] word,
                       output int lat, output int nrd, output int nwr);
    int n;
    int base;
    longint unsigned v;
    n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err  = (sz == 2'd3) || (ad >= 32'd1024) || (ad % n != 0);
    rd   = '0;
    word = '0;
    lat  = 1; nrd = 0; nwr = 0;
    if (!err) begin
      base = int'(ad) - int'(ad % 4);
      v = 0;
      if (wr) begin
        for (int i = 0; i < n; i++) ref_bytes[int'(ad) + i] = wd[8*i +: 8];
        for (int i = 0; i < 4; i++) v += longint'(ref_bytes[base + i]) << (8 * i);
        word = v[31:0];
        lat  = (n == 4) ? 2 : 3;
        nrd  = (n == 4) ? 0 : 1;
        nwr  = 1;
      end else begin
        for (int i = 0; i < n; i++) v += longint'(ref_bytes[int'(ad) + i]) << (8 * i);
        if (sg && n < 4 && v >= (64'd1 << (8 * n - 1)))
          v = v + (64'd1 << 32) - (64'd1 << (8 * n));
        rd  = v[31:0];
        lat = 2;
        nrd = 1;
      end
    end
  endtask

  task automatic do_req(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] ad, input logic [31:0] wd,
                        output logic [31:0] got, output logic [31:0] wgot);
    logic        e_err, got_err;
    logic [31:0] e_rd, e_word;
    int          e_lat, e_nrd, e_nwr, lat, nrd, nwr, both;
    model(wr, sz, sg, ad, wd, e_err, e_rd, e_word, e_lat, e_nrd, e_nwr);
    @(negedge clk);
    check({tag, ":ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = ad;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0; nrd = 0; nwr = 0; both = 0;
    got = 'x; wgot = 'x; got_err = 1'bx;
    for (int c = 1; c <= 6 && lat == 0; c++) begin
      @(negedge clk);
      nrd  += int'(bus.mem_read);
      nwr  += int'(bus.mem_write);
      both += int'(bus.mem_read && bus.mem_write);
      if (bus.mem_write) wgot = bus.mem_wdata;
      if (bus.resp_valid) begin
        lat     = c;
        got     = bus.resp_rdata;
        got_err = bus.resp_err;
      end
    end
    check({tag, ":latency"}, 32'(lat), 32'(e_lat));
    check({tag, ":err"}, 32'(got_err), 32'(e_err));
    check({tag, ":rdata"}, got, e_rd);
    check({tag, ":reads"}, 32'(nrd), 32'(e_nrd));
    check({tag, ":writes"}, 32'(nwr), 32'(e_nwr));
    check({tag, ":both_strobes"}, 32'(both), 32'd0);
    if (wr && !e_err) check({tag, ":wdata"}, wgot, e_word);
    @(negedge clk);
    check({tag, ":pulse_end"}, 32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, wgot, w;
    logic [31:0] exp_b2b [3];
    logic        e_err;
    logic [31:0] e_word;
    int          e_lat, e_nrd, e_nwr;
    int          cyc, acc, nresp, rdy_cnt;
    int          acc_cyc [3];
    int          resp_cyc [3];
    logic        rdy, rv;

    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      ram[i] = w;
      for (int b = 0; b < 4; b++) ref_bytes[4 * i + b] = w[8*b +: 8];
    end
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

    // Reset state
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst:ready", 32'(bus.req_ready), 32'd0);
    check("rst:resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst:resp_err", 32'(bus.resp_err), 32'd0);
    check("rst:resp_rdata", bus.resp_rdata, 32'd0);
    check("rst:strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    check("rst:mem_addr", bus.mem_addr, 32'd0);
    rst = 1'b0;
    #1 check("rst:ready_after", 32'(bus.req_ready), 32'd1);

    // Word store then load
    do_req("st_w", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, got, wgot);
    do_req("ld_w", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got, wgot);
    check("ld_w:value", got, 32'hDEADBEEF);

    // Byte read-modify-write
    do_req("st_b", 1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AB, got, wgot);
    check("st_b:merged", wgot, 32'hDEABBEEF);
    do_req("ld_w2", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got, wgot);
    check("ld_w2:value", got, 32'hDEABBEEF);

    // Extension
    do_req("st_ext", 1'b1, 2'b10, 1'b0, 32'h20, 32'h80017F80, got, wgot);
    do_req("ld_hs", 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, got, wgot);
    check("ld_hs:value", got, 32'hFFFF8001);
    do_req("ld_hu", 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, got, wgot);
    check("ld_hu:value", got, 32'h00008001);
    do_req("ld_bs0", 1'b0, 2'b00, 1'b1, 32'h20, 32'h0, got, wgot);
    check("ld_bs0:value", got, 32'hFFFFFF80);
    do_req("ld_bs1", 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, got, wgot);
    check("ld_bs1:value", got, 32'h0000007F);

    // Errors
    do_req("err_wmis", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, got, wgot);
    do_req("err_hmis", 1'b1, 2'b01, 1'b0, 32'h21, 32'h1234, got, wgot);
    do_req("err_size", 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, got, wgot);
    do_req("err_range", 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, got, wgot);

    // Reset during the WR cycle of a byte store, before the falling edge
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = 32'h12; bus.req_wdata = 32'h55;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #1 check("abort:wr_cycle", 32'(bus.mem_write), 32'd1);
    rst = 1'b1;
    #1 check("abort:wr_drop", 32'(bus.mem_write), 32'd0);
    rv = 1'b0;
    repeat (2) @(negedge clk) rv |= bus.resp_valid;
    rst = 1'b0;
    #1 check("abort:ready", 32'(bus.req_ready), 32'd1);
    repeat (3) @(negedge clk) rv |= bus.resp_valid;
    check("abort:no_resp", 32'(rv), 32'd0);
    do_req("abort_ld", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got, wgot);
    check("abort_ld:value", got, 32'hDEABBEEF);

    // Back-to-back loads with req_valid held high
    model(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, e_err, exp_b2b[0], e_word, e_lat, e_nrd, e_nwr);
    model(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, e_err, exp_b2b[1], e_word, e_lat, e_nrd, e_nwr);
    model(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, e_err, exp_b2b[2], e_word, e_lat, e_nrd, e_nwr);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'b10;
    bus.req_signed = 1'b0; bus.req_addr = 32'h10;
    cyc = 0; acc = 0; nresp = 0; rdy_cnt = 0;
    while (nresp < 3 && cyc < 40) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      if (bus.resp_valid) begin
        check($sformatf("b2b:rdata%0d", nresp), bus.resp_rdata, exp_b2b[nresp]);
        resp_cyc[nresp] = cyc;
        nresp++;
      end
      rdy = bus.req_ready;
      rdy_cnt += int'(rdy);
      @(posedge clk);
      if (rdy && bus.req_valid) begin
        acc_cyc[acc] = cyc;
        acc++;
        #1;
        case (acc)
          1: begin bus.req_size = 2'b01; bus.req_signed = 1'b1; bus.req_addr = 32'h22; end
          2: begin bus.req_size = 2'b00; bus.req_signed = 1'b0; bus.req_addr = 32'h21; end
          default: bus.req_valid = 1'b0;
        endcase
      end
    end
    check("b2b:accepts", 32'(acc), 32'd3);
    check("b2b:responses", 32'(nresp), 32'd3);
    check("b2b:ready_cycles", 32'(rdy_cnt), 32'd3);
    if (acc == 3 && nresp == 3) begin
      check("b2b:gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
      check("b2b:gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
      for (int i = 0; i < 3; i++)
        check($sformatf("b2b:lat%0d", i), 32'(resp_cyc[i] - acc_cyc[i]), 32'd2);
    end

    // Random traffic
    for (int t = 0; t < 60; t++) begin
      logic [1:0]  sz;
      logic [31:0] ad;
      int          sel;
      sz  = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      if (sel == 0) ad = 32'd1024 + 32'($urandom_range(0, 4095));
      else          ad = 32'($urandom_range(0, 1023));
      if (sel < 7 && sz == 2'b01) ad[0] = 1'b0;
      if (sel < 7 && sz == 2'b10) ad[1:0] = 2'b00;
      do_req($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
             ad, $urandom, got, wgot);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator between the MIPS pipeline's MEM stage and the word-addressed data RAM. It accepts one byte, halfword or word request at a time and drives the RAM's read strobe, write strobe, address and write data. Sub-word stores are done as read-modify-write because the RAM has no byte enables. It returns sign- or zero-extended load data with a one-cycle response pulse and flags misaligned or out-of-range accesses without touching memory.

## Interface
- ADDR_LIMIT, 1024: byte size of the data RAM (256 words). Any address >= ADDR_LIMIT is an error.
- clk  in  1  system clock; FSM advances on posedge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block idle and able to accept
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed  in  1  loads only: 1 sign-extends, 0 zero-extends
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  qualified by resp_valid; misaligned, illegal size or out of range
- mem_addr  out  32  RAM byte address, always {a[31:2],2'b00}
- mem_wdata  out  32  RAM write data
- mem_read  out  1  RAM read strobe (RAM read path is combinational)
- mem_write  out  1  RAM write strobe (RAM commits on negedge of the same cycle)
- mem_rdata  in  32  RAM read data

## Operation
- States: IDLE, RD, WR, RESP.
- A request is accepted when req_valid && req_ready at a posedge. At acceptance, addr, size, signed, write and wdata are latched.
- req_ready = (state==IDLE) && !rst.
- Error check at acceptance:
  - halfword with addr[0]=1
  - word with addr[1:0]!=0
  - size=11
  - addr >= ADDR_LIMIT
- Transitions:
  - Error: IDLE->RESP with resp_err=1. No memory strobes.
  - Load: IDLE->RD->RESP.
  - Word store: IDLE->WR->RESP.
  - Byte or halfword store: IDLE->RD->WR->RESP.
  - RESP->IDLE unconditionally.
- RD: mem_read=1 and mem_addr is driven. mem_rdata is captured into an internal word register at the closing posedge.
- WR: mem_write=1.
  - Word store: mem_wdata = latched wdata.
  - Sub-word store: mem_wdata = the captured word with the target lane replaced.
- Lanes are little-endian:
  - byte lane k (k = addr[1:0]) is bits 8k+7:8k
  - halfword lane addr[1]=0 is bits 15:0, addr[1]=1 is bits 31:16
- Load extraction: select the lane from the captured word, then sign- or zero-extend to 32 bits per latched signed. Word loads ignore signed.
- mem_read and mem_write are decoded from state only. They are never both high.
- Outside RD/WR: mem_addr=0, mem_wdata=0.
- resp_rdata is registered and held until the next RESP. It is 0 for stores and errors.

## Timing
- Reset (async): state=IDLE. All outputs 0 except req_ready, which is 0 while rst=1 and 1 after release.
- Latency from the accept edge to the resp_valid cycle:
  - error: 1 cycle
  - load and word store: 2 cycles
  - sub-word store: 3 cycles
- Throughput: the next accept is possible at the posedge ending RESP+1 (IDLE). With req_valid held high, requests are spaced latency+1 cycles apart.
- A request arriving while busy is not accepted (req_ready=0). The requester holds its fields stable until acceptance.
- Reset mid-operation:
  - The operation is aborted and no resp_valid is issued.
  - mem_write drops asynchronously. If rst rises before the negedge of a WR cycle, no RAM write occurs.
- resp_valid is high for exactly one cycle per accepted request.

## Test plan
- Word store then load: store 0xDEADBEEF to 0x10, then load word from 0x10.
  - Store: mem_write high exactly 1 cycle, resp_valid 2 cycles after accept.
  - Load: resp_rdata=0xDEADBEEF, resp_err=0.
- Byte read-modify-write: store byte 0xAB to 0x12 over 0xDEADBEEF.
  - Sequence RD then WR, with mem_wdata=0xDEABBEEF in WR.
  - resp_valid 3 cycles after accept.
  - Word load from 0x10 then returns 0xDEABBEEF.
- Extension: word 0x8001_7F80 at 0x20.
  - signed half @0x22 -> 0xFFFF8001
  - unsigned half @0x22 -> 0x00008001
  - signed byte @0x20 -> 0xFFFFFF80
  - signed byte @0x21 -> 0x0000007F
- Errors: word load @0x13, half store @0x21, size=11 @0x0, word load @0x400.
  - Each gives resp_valid with resp_err=1 one cycle after accept and resp_rdata=0.
  - mem_read and mem_write never assert.
- Reset mid-store: assert rst during the WR cycle of a byte store to 0x12, before the negedge.
  - mem_write drops immediately and no resp_valid is issued.
  - req_ready=1 after release.
  - Word at 0x10 is unchanged.
- Back-to-back: req_valid held high with 3 queued loads.
  - req_ready is low while busy.
  - Accepts occur every 3 cycles with three resp_valid pulses in order.
